dsp_onepole_mc: RTL and testbench

Multi-channel, time-multiplexed one-pole filter with per-channel cutoff and optional lowpass/highpass mode. Each channel computes `y += cutoff * (x - y)` in signed fixed point using one shared multiply-accumulate datapath, one channel per cycle. It sits in the synth voice chain after oscillator/mixer stages and replaces per-voice single-channel lowpass instances.

---
 rtl/dsp_onepole_pkg.sv | 17 +
 rtl/dsp_onepole_mc_if.sv | 24 ++
 rtl/onepole_mac.sv | 28 ++
 rtl/dsp_onepole_mc.sv | 140 ++++++++++++++
 tb/tb_dsp_onepole_mc.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_onepole_pkg.sv
// Shared types and constants for the multi-channel one-pole filter.
package dsp_onepole_pkg;

  localparam logic MODE_LP = 1'b0;
  localparam logic MODE_HP = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } op_state_t;

  function automatic int fx_one(input int frac);
    return 1 << frac;
  endfunction

endpackage

// File: rtl/dsp_onepole_mc_if.sv
// Frame handshake plus packed per-channel sample/coefficient lanes for dsp_onepole_mc.
interface dsp_onepole_mc_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  logic                      frame_valid;
  logic                      in_ready;
  logic                      clear;
  logic [CHANNELS*WIDTH-1:0] sigIn;
  logic [CHANNELS*WIDTH-1:0] cutoff;
  logic [CHANNELS-1:0]       mode;
  logic [CHANNELS*WIDTH-1:0] sigOut;
  logic                      frame_done;

  modport master (
    output frame_valid, clear, sigIn, cutoff, mode,
    input  in_ready, sigOut, frame_done
  );

  modport slave (
    input  frame_valid, clear, sigIn, cutoff, mode,
    output in_ready, sigOut, frame_done
  );
endinterface

// File: rtl/onepole_mac.sv
// One-pole update arithmetic: y = sat(state + floor(diff * coef / 2^FRAC)).
module onepole_mac #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 14
) (
  input  logic signed [WIDTH:0]   diff,
  input  logic signed [WIDTH-1:0] coef,
  input  logic signed [WIDTH-1:0] state,
  output logic signed [WIDTH-1:0] y
);
  localparam int PW = 2 * WIDTH + 1;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_sh;
  logic signed [PW:0]   sum;

  // Low PW bits of a two's complement product do not depend on signedness.
  assign prod    = {{WIDTH{diff[WIDTH]}}, diff} * {{(WIDTH+1){coef[WIDTH-1]}}, coef};
  assign prod_sh = prod >>> FRAC;
  assign sum     = {prod_sh[PW-1], prod_sh} + {{(PW+1-WIDTH){state[WIDTH-1]}}, state};

  always_comb begin
    y = sum[WIDTH-1:0];
    if (sum[PW:WIDTH-1] != {(PW-WIDTH+2){sum[PW]}}) begin
      y = sum[PW] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
endmodule

// File: rtl/dsp_onepole_mc.sv
// Time-multiplexed one-pole filter bank: one channel per cycle through a shared MAC.
// Per-channel highpass output exists only when ONEPOLE_HP_EN is defined.
module dsp_onepole_mc
  import dsp_onepole_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 14,
  parameter int CHANNELS = 4
) (
  input  logic            clk,
  input  logic            rst,
  dsp_onepole_mc_if.slave bus
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(fx_one(FRAC));
  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  op_state_t st, st_nxt;
  logic                    accept;
  logic [CW-1:0]           ch, b_ch;
  logic                    b_vld, done;
  logic signed [WIDTH:0]   diff_q;
  logic signed [WIDTH-1:0] x_q   [CHANNELS];
  logic signed [WIDTH-1:0] cut_q [CHANNELS];
  logic signed [WIDTH-1:0] ys_q  [CHANNELS];
  logic signed [WIDTH-1:0] out_q [CHANNELS];
  logic signed [WIDTH-1:0] mac_y, y_out;
  logic [CHANNELS*WIDTH-1:0] sig_out_w;

  function automatic logic signed [WIDTH-1:0] clamp_cut(input logic signed [WIDTH-1:0] c);
    if (c[WIDTH-1]) return '0;
    if (c > ONE)    return ONE;
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= S_IDLE;
      ch <= '0;
    end else begin
      st <= st_nxt;
      ch <= (st == S_RUN && st_nxt == S_RUN) ? ch + 1'b1 : '0;
    end
  end

  always_comb begin
    st_nxt = st;
    accept = 1'b0;
    case (st)
      S_IDLE:  if (bus.frame_valid) begin
                 st_nxt = S_RUN;
                 accept = 1'b1;
               end
      S_RUN:   if (ch == CW'(CHANNELS - 1)) st_nxt = S_DRAIN;
      S_DRAIN: st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
    // Clear wins over a new frame and aborts one in flight.
    if (bus.clear) begin
      st_nxt = S_IDLE;
      accept = 1'b0;
    end
  end

  onepole_mac #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mac (
    .diff  (diff_q),
    .coef  (cut_q[b_ch]),
    .state (ys_q[b_ch]),
    .y     (mac_y)
  );

`ifdef ONEPOLE_HP_EN
  logic [CHANNELS-1:0]   mode_q;
  logic signed [WIDTH:0] hp_diff;

  assign hp_diff = {x_q[b_ch][WIDTH-1], x_q[b_ch]} - {mac_y[WIDTH-1], mac_y};

  always_comb begin
    y_out = mac_y;
    if (mode_q[b_ch] == MODE_HP) begin
      if (hp_diff[WIDTH] != hp_diff[WIDTH-1]) y_out = hp_diff[WIDTH] ? MINV : MAXV;
      else                                    y_out = hp_diff[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         mode_q <= '0;
    else if (accept) mode_q <= bus.mode;
  end
`else
  logic mode_unused;
  assign mode_unused = ^bus.mode;
  assign y_out       = mac_y;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done   <= 1'b0;
      b_vld  <= 1'b0;
      b_ch   <= '0;
      diff_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        x_q[c]   <= '0;
        cut_q[c] <= '0;
        ys_q[c]  <= '0;
        out_q[c] <= '0;
      end
    end else begin
      done   <= (st == S_DRAIN) && !bus.clear;
      b_vld  <= (st == S_RUN) && !bus.clear;
      b_ch   <= ch;
      diff_q <= {x_q[ch][WIDTH-1], x_q[ch]} - {ys_q[ch][WIDTH-1], ys_q[ch]};
      if (accept) begin
        for (int c = 0; c < CHANNELS; c++) begin
          x_q[c]   <= bus.sigIn[c*WIDTH +: WIDTH];
          cut_q[c] <= clamp_cut(bus.cutoff[c*WIDTH +: WIDTH]);
        end
      end
      if (bus.clear) begin
        for (int c = 0; c < CHANNELS; c++) begin
          ys_q[c]  <= '0;
          out_q[c] <= '0;
        end
      end else if (b_vld) begin
        ys_q[b_ch]  <= mac_y;
        out_q[b_ch] <= y_out;
      end
    end
  end

  always_comb begin
    sig_out_w = '0;
    for (int c = 0; c < CHANNELS; c++) sig_out_w[c*WIDTH +: WIDTH] = out_q[c];
  end

  assign bus.sigOut     = sig_out_w;
  assign bus.in_ready   = (st == S_IDLE);
  assign bus.frame_done = done;
endmodule

// File: tb/tb_dsp_onepole_mc.sv
// Scoreboarded bench for dsp_onepole_mc against a frame-level arithmetic model.
module tb_dsp_onepole_mc;
  localparam int W    = 16;
  localparam int FR   = 14;
  localparam int CH   = 4;
  localparam int ONE  = 1 << FR;
  localparam int MAXV = (1 << (W-1)) - 1;
  localparam int MINV = -(1 << (W-1));
`ifdef ONEPOLE_HP_EN
  localparam bit HP_EN = 1'b1;
`else
  localparam bit HP_EN = 1'b0;
`endif

  typedef logic [CH*W-1:0] vec_t;
  typedef struct {
    vec_t v;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0, n_err = 0, n_acc = 0;
  exp_t sb[$];
  int   m_st [CH];

  dsp_onepole_mc_if #(.WIDTH(W), .CHANNELS(CH)) bus ();
  dsp_onepole_mc #(.WIDTH(W), .FRAC(FR), .CHANNELS(CH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic int lane(input vec_t v, input int c);
    return $signed(v[c*W +: W]);
  endfunction

  function automatic vec_t mk(input int l0, input int l1, input int l2, input int l3);
    return {l3[W-1:0], l2[W-1:0], l1[W-1:0], l0[W-1:0]};
  endfunction

  function automatic int rand_x();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  function automatic int rand_cut();
    return int'($urandom_range(0, 19999)) - 1500;
  endfunction

  // Whole-frame reference: every channel advances once, y += clamp(k) * (x - y).
  task automatic model_frame(input vec_t xv, input vec_t cv, input logic [CH-1:0] mv, output vec_t o);
    o = '0;
    for (int c = 0; c < CH; c++) begin
      int x, k, y, r;
      x = lane(xv, c);
      k = lane(cv, c);
      if (k < 0)   k = 0;
      if (k > ONE) k = ONE;
      y = sat(m_st[c] + (((x - m_st[c]) * k) >>> FR));
      m_st[c] = y;
      r = (HP_EN && mv[c]) ? sat(x - y) : y;
      o[c*W +: W] = r[W-1:0];
    end
  endtask

  // Observer: frame acceptance, clear and reset as seen at the DUT boundary.
  always @(negedge clk) begin
    vec_t o;
    if (rst) begin
      sb.delete();
      for (int c = 0; c < CH; c++) m_st[c] = 0;
    end else if (bus.clear) begin
      if (!bus.in_ready && sb.size() > 0) void'(sb.pop_back());
      for (int c = 0; c < CH; c++) m_st[c] = 0;
    end else if (bus.frame_valid && bus.in_ready) begin
      n_acc++;
      model_frame(bus.sigIn, bus.cutoff, bus.mode, o);
      sb.push_back('{v: o, cyc: cyc});
    end
  end

  // Monitor: every frame_done must match the oldest outstanding frame.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.frame_done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_done: frame_done with no frame outstanding (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("frame_out", bus.sigOut, e.v);
        check("done_latency", cyc - e.cyc, CH + 2);
        check("ready_at_done", bus.in_ready, 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !bus.in_ready; i++) tick();
    check("ready_wait", bus.in_ready, 1);
  endtask

  task automatic run_frame(input vec_t xv, input vec_t cv, input logic [CH-1:0] mv);
    bit seen;
    tick();
    wait_ready();
    bus.sigIn = xv; bus.cutoff = cv; bus.mode = mv; bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    bus.sigIn  = {$urandom, $urandom};
    bus.cutoff = {$urandom, $urandom};
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.frame_done;
    end
    check("frame_done_seen", seen, 1);
  endtask

  task automatic do_clear();
    tick();
    wait_ready();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
    check("drain", sb.size(), 0);
  endtask

  initial begin
    int a0;
    int hp_exp [3];
    bus.frame_valid = 1'b0; bus.clear = 1'b0; bus.mode = '0;
    bus.sigIn = '0; bus.cutoff = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("rst_sigout", bus.sigOut, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_frame_done", bus.frame_done, 0);

    // Ch0 lowpass step with explicit handshake timing on the first frame.
    tick();
    bus.sigIn = mk(8192, 0, 0, 0); bus.cutoff = mk(8192, 0, 0, 0); bus.mode = '0;
    bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    for (int k = 1; k <= CH + 1; k++) begin
      check("busy_in_ready", bus.in_ready, 0);
      tick();
    end
    check("done_cycle", bus.frame_done, 1);
    check("ch0_f1", lane(bus.sigOut, 0), 4096);
    run_frame(mk(8192, 0, 0, 0), mk(8192, 0, 0, 0), '0);
    check("ch0_f2", lane(bus.sigOut, 0), 6144);
    run_frame(mk(8192, 0, 0, 0), mk(8192, 0, 0, 0), '0);
    check("ch0_f3", lane(bus.sigOut, 0), 7168);
    check("ch0_hold_lane1", lane(bus.sigOut, 1), 0);

    // Cutoff of exactly 1.0, above 1.0 (clamped) and negative (clamped to 0).
    do_clear();
    check("clear_zero", bus.sigOut, 0);
    run_frame(mk(0, 8192, 0, 0), mk(0, 16384, 0, 0), '0);
    check("ch1_cut_one", lane(bus.sigOut, 1), 8192);
    do_clear();
    run_frame(mk(0, 8192, 0, 0), mk(0, 20000, 0, 0), '0);
    check("ch1_cut_over", lane(bus.sigOut, 1), 8192);
    do_clear();
    run_frame(mk(0, 8192, 0, 0), mk(0, -5, 0, 0), '0);
    check("ch1_cut_neg", lane(bus.sigOut, 1), 0);

    // Full-scale swing on ch2 must not wrap.
    do_clear();
    run_frame(mk(0, 0, -32768, 0), mk(0, 0, 16384, 0), '0);
    check("ch2_neg_full", lane(bus.sigOut, 2), -32768);
    run_frame(mk(0, 0, 32767, 0), mk(0, 0, 16384, 0), '0);
    check("ch2_pos_full", lane(bus.sigOut, 2), 32767);

    // Ch3 in highpass mode (lowpass response when the feature is built out).
    do_clear();
    hp_exp = HP_EN ? '{4096, 2048, 1024} : '{4096, 6144, 7168};
    for (int f = 0; f < 3; f++) begin
      run_frame(mk(0, 0, 0, 8192), mk(0, 0, 0, 8192), 4'b1000);
      check("ch3_mode", lane(bus.sigOut, 3), hp_exp[f]);
    end

    // frame_valid held high: one accept every CH+2 cycles.
    tick();
    wait_ready();
    a0 = n_acc;
    bus.frame_valid = 1'b1;
    for (int i = 0; i < 19; i++) begin
      bus.sigIn  = mk(rand_x(), rand_x(), rand_x(), rand_x());
      bus.cutoff = mk(rand_cut(), rand_cut(), rand_cut(), rand_cut());
      bus.mode   = CH'($urandom_range(0, (1 << CH) - 1));
      tick();
    end
    bus.frame_valid = 1'b0;
    check("held_accepts", n_acc - a0, 4);
    drain();

    // A pulse while busy is dropped.
    tick();
    wait_ready();
    a0 = n_acc;
    bus.sigIn = mk(rand_x(), rand_x(), rand_x(), rand_x());
    bus.cutoff = mk(rand_cut(), rand_cut(), rand_cut(), rand_cut());
    bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    tick();
    bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    drain();
    repeat (8) tick();
    check("busy_pulse_ignored", n_acc - a0, 1);

    // Clear together with frame_valid: zero state, nothing starts.
    tick();
    wait_ready();
    a0 = n_acc;
    bus.clear = 1'b1; bus.frame_valid = 1'b1;
    tick();
    bus.clear = 1'b0; bus.frame_valid = 1'b0;
    check("clr_vld_zero", bus.sigOut, 0);
    tick();
    check("clr_vld_idle", bus.in_ready, 1);
    check("clr_vld_no_accept", n_acc - a0, 0);
    run_frame(mk(8192, 0, 0, 0), mk(8192, 0, 0, 0), '0);
    check("after_clear_ch0", lane(bus.sigOut, 0), 4096);

    // Clear mid-frame aborts without frame_done.
    tick();
    wait_ready();
    bus.sigIn = mk(rand_x(), rand_x(), rand_x(), rand_x());
    bus.cutoff = mk(16384, 16384, 16384, 16384);
    bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("abort_idle", bus.in_ready, 1);
    check("abort_zero", bus.sigOut, 0);
    repeat (10) tick();

    // Randomised frames with gaps and occasional clears.
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 7) == 0) do_clear();
      run_frame(mk(rand_x(), rand_x(), rand_x(), rand_x()),
                mk(rand_cut(), rand_cut(), rand_cut(), rand_cut()),
                CH'($urandom_range(0, (1 << CH) - 1)));
    end

    // Reset in cycle 3 of a frame discards it.
    tick();
    wait_ready();
    bus.sigIn = mk(rand_x(), rand_x(), rand_x(), rand_x());
    bus.cutoff = mk(16384, 16384, 16384, 16384);
    bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_sigout", bus.sigOut, 0);
    check("midrst_done", bus.frame_done, 0);
    check("midrst_ready", bus.in_ready, 1);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("post_rst_sigout", bus.sigOut, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
